// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin arbiter that lets N AXI-stream
// requesters share a single uart_tx byte stream. A grant is held from the first
// beat until the tlast beat, so packets from different sources never interleave.
// The data path is a pure combinational mux; uart_tx registers the byte itself.
// Build option: define UART_TX_ARB_HEADER_EN to prefix every packet with a
// header beat {4'hF, grant index} so the receiver can tell the sources apart.

module uart_tx_arbiter #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = $clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [N-1:0]            s_axis_tvalid,
  input  logic [N-1:0]            s_axis_tlast,
  output logic [N-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic [IDX_W-1:0]        grant_idx,
  output logic                    grant_valid,
  output logic                    busy
);

`ifdef UART_TX_ARB_HEADER_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_XFER = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd2
  } state_t;
`endif

  state_t                r_state;
  state_t                w_nextState;
  logic [IDX_W-1:0]      r_grantIdx;
  logic [IDX_W-1:0]      w_nextGrantIdx;
  logic                  r_grantValid;
  logic                  w_nextGrantValid;
  logic [IDX_W-1:0]      r_lastIdx;
  logic [IDX_W-1:0]      w_nextLastIdx;

  logic                  w_pickFound;
  logic [IDX_W-1:0]      w_pickIdx;
  logic [IDX_W-1:0]      w_candIdx;

  logic [DATA_WIDTH-1:0] w_grantData;
  logic                  w_grantValidIn;
  logic                  w_grantLast;

  // Selected requester's beat; only meaningful while a grant is active.
  assign w_grantData    = s_axis_tdata[int'(r_grantIdx)*DATA_WIDTH +: DATA_WIDTH];
  assign w_grantValidIn = s_axis_tvalid[r_grantIdx];
  assign w_grantLast    = s_axis_tlast[r_grantIdx];

`ifdef UART_TX_ARB_HEADER_EN
  logic [DATA_WIDTH-1:0] w_hdrData;

  // Header beat: upper nibble 0xF marks it as a header, lower nibble is the source.
  always_comb begin
    w_hdrData      = '0;
    w_hdrData[7:4] = 4'hF;
    w_hdrData[3:0] = 4'(r_grantIdx);
  end
`endif

  // Round-robin search: first valid port after the last one served, wrapping at N.
  always_comb begin
    w_pickFound = 1'b0;
    w_pickIdx   = '0;
    w_candIdx   = '0;
    for (int k = 1; k <= N; k++) begin
      w_candIdx = IDX_W'((int'(r_lastIdx) + k) % N);
      if (!w_pickFound && s_axis_tvalid[w_candIdx]) begin
        w_pickFound = 1'b1;
        w_pickIdx   = w_candIdx;
      end
    end
  end

  // Next-state and output decode; outputs are idle unless a grant is in progress.
  always_comb begin
    w_nextState      = r_state;
    w_nextGrantIdx   = r_grantIdx;
    w_nextGrantValid = r_grantValid;
    w_nextLastIdx    = r_lastIdx;
    s_axis_tready    = '0;
    m_axis_tvalid    = 1'b0;
    m_axis_tdata     = '0;

    case (r_state)
      ST_IDLE: begin
        if (w_pickFound) begin
          w_nextGrantIdx   = w_pickIdx;
          w_nextGrantValid = 1'b1;
`ifdef UART_TX_ARB_HEADER_EN
          w_nextState      = ST_HDR;
`else
          w_nextState      = ST_XFER;
`endif
        end
      end

`ifdef UART_TX_ARB_HEADER_EN
      ST_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = w_hdrData;
        if (m_axis_tready) begin
          w_nextState = ST_XFER;
        end
      end
`endif

      ST_XFER: begin
        m_axis_tdata              = w_grantData;
        m_axis_tvalid             = w_grantValidIn;
        s_axis_tready[r_grantIdx] = m_axis_tready;
        if (w_grantValidIn && m_axis_tready && w_grantLast) begin
          w_nextLastIdx    = r_grantIdx;
          w_nextGrantValid = 1'b0;
          w_nextState      = ST_IDLE;
        end
      end

      default: begin
        w_nextGrantValid = 1'b0;
        w_nextState      = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer registers; port 0 wins first after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grantIdx   <= '0;
      r_grantValid <= 1'b0;
      r_lastIdx    <= IDX_W'(N - 1);
    end else begin
      r_state      <= w_nextState;
      r_grantIdx   <= w_nextGrantIdx;
      r_grantValid <= w_nextGrantValid;
      r_lastIdx    <= w_nextLastIdx;
    end
  end

  assign grant_idx   = r_grantIdx;
  assign grant_valid = r_grantValid;
  assign busy        = r_grantValid | m_axis_tvalid;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter. Packet sources are fed from per-port queues;
// an ownership/pointer reference model predicts every output each cycle, and a
// per-port scoreboard confirms that every byte leaves exactly once, in order.
// Honours UART_TX_ARB_HEADER_EN to expect the header beat.

module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int IW = 2;
`ifdef UART_TX_ARB_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef struct packed {
    logic [7:0]    gap;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk    = 1'b0;
  logic          rst    = 1'b1;
  logic [N*DW-1:0] sData  = '0;
  logic [N-1:0]  sValid = '0;
  logic [N-1:0]  sLast  = '0;
  logic [N-1:0]  sReady;
  logic [DW-1:0] mData;
  logic          mValid;
  logic          mReady = 1'b1;
  logic [IW-1:0] grantIdx;
  logic          grantValid;
  logic          busy;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  uart_tx_arbiter #(.N(N), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (sData),
    .s_axis_tvalid (sValid),
    .s_axis_tlast  (sLast),
    .s_axis_tready (sReady),
    .m_axis_tdata  (mData),
    .m_axis_tvalid (mValid),
    .m_axis_tready (mReady),
    .grant_idx     (grantIdx),
    .grant_valid   (grantValid),
    .busy          (busy)
  );

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  beat_t srcQ[N][$];
  beat_t refQ[N][$];
  int    waitCnt[N];
  logic [N-1:0] acc;
  bit    randValid;
  int    readyMode;
  int    readyPat[$];

  int mOwner;
  int mPtr;
  int mGrant;
  bit mHdr;
  bit mKnown;

  int         grantLog[$];
  logic [7:0] payLog[$];
  logic [7:0] hdrLog[$];
  int         payCyc[$];
  int         firstValid;
  logic [7:0] expPay[$];
  int         expGrant[$];

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic addPacket(input int port, input int len, input logic [7:0] base,
                           input int gapAt, input int gapLen);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.data = base + 8'(i);
      b.last = (i == len - 1);
      b.gap  = (i == gapAt) ? 8'(gapLen) : 8'd0;
      srcQ[port].push_back(b);
      refQ[port].push_back(b);
    end
  endtask

  task automatic applyStimulus();
    for (int p = 0; p < N; p++) begin
      if (acc[p]) begin
        if (srcQ[p].size() > 0) void'(srcQ[p].pop_front());
        waitCnt[p] = -1;
        sValid[p]  = 1'b0;
      end
      if (rst || srcQ[p].size() == 0) begin
        sValid[p] = 1'b0;
      end else if (!sValid[p]) begin
        if (waitCnt[p] < 0) waitCnt[p] = int'(srcQ[p][0].gap);
        if (waitCnt[p] > 0) waitCnt[p]--;
        else sValid[p] = randValid ? ($urandom % 4 != 0) : 1'b1;
      end
      if (sValid[p]) begin
        sData[p*DW +: DW] = srcQ[p][0].data;
        sLast[p]          = srcQ[p][0].last;
      end else begin
        sData[p*DW +: DW] = DW'($urandom);
        sLast[p]          = 1'($urandom);
      end
    end
    case (readyMode)
      0:       mReady = 1'b1;
      1:       mReady = ($urandom % 3 != 0);
      default: mReady = (readyPat.size() > 0) ? (readyPat.pop_front() != 0) : 1'b1;
    endcase
  endtask

  // One clock: compare at negedge, advance model, then drive the next inputs.
  task automatic stepCycle();
    logic [N-1:0]  eReady;
    logic          eValid;
    logic [DW-1:0] eData;
    @(negedge clk);
    cyc++;
    if (firstValid < 0 && sValid != '0) firstValid = cyc;
    acc = sValid & sReady;
    if (mKnown) begin
      eReady = '0;
      eValid = 1'b0;
      eData  = '0;
      if (mOwner >= 0) begin
        if (mHdr) begin
          eValid = 1'b1;
          eData  = 8'hF0 | 8'(mOwner);
        end else begin
          eData          = sData[mOwner*DW +: DW];
          eValid         = sValid[mOwner];
          eReady[mOwner] = mReady;
        end
      end
      checkOutput("s_axis_tready", sReady, eReady);
      checkOutput("m_axis_tvalid", mValid, eValid);
      checkOutput("m_axis_tdata", mData, eData);
      checkOutput("grant_valid", grantValid, mOwner >= 0);
      checkOutput("grant_idx", grantIdx, mGrant);
      checkOutput("busy", busy, (mOwner >= 0) || eValid);
    end
    if (rst) begin
      mOwner = -1;
      mPtr   = N - 1;
      mGrant = 0;
      mHdr   = 1'b0;
      mKnown = 1'b1;
    end else if (mKnown) begin
      if (mOwner < 0) begin
        for (int k = 1; k <= N; k++) begin
          int c = (mPtr + k) % N;
          if (mOwner < 0 && sValid[c]) mOwner = c;
        end
        if (mOwner >= 0) begin
          mGrant = mOwner;
          mHdr   = (HDR != 0);
          grantLog.push_back(mOwner);
        end
      end else if (mHdr) begin
        if (mReady) begin
          mHdr = 1'b0;
          hdrLog.push_back(mData);
        end
      end else if (sValid[mOwner] && mReady) begin
        payLog.push_back(mData);
        payCyc.push_back(cyc);
        checkOutput("sb_pending", refQ[mOwner].size() != 0, 1);
        if (refQ[mOwner].size() != 0) begin
          beat_t e;
          e = refQ[mOwner].pop_front();
          checkOutput("sb_data", mData, e.data);
          checkOutput("sb_last", sLast[mOwner], e.last);
        end
        if (sLast[mOwner]) begin
          mPtr   = mOwner;
          mOwner = -1;
        end
      end
    end
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  task automatic applyReset();
    rst = 1'b1;
    for (int p = 0; p < N; p++) begin
      srcQ[p].delete();
      refQ[p].delete();
      waitCnt[p] = -1;
    end
    stepCycle();
    stepCycle();
    rst = 1'b0;
  endtask

  function automatic bit drained();
    bit d = (mOwner < 0);
    for (int p = 0; p < N; p++) if (srcQ[p].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic waitDrain(input int limit);
    int n = 0;
    while (!drained() && n < limit) begin
      stepCycle();
      n++;
    end
    checkOutput("drain_done", drained(), 1);
    stepCycle();
  endtask

  task automatic clearLogs();
    grantLog.delete();
    payLog.delete();
    hdrLog.delete();
    payCyc.delete();
    firstValid = -1;
  endtask

  task automatic checkLogs(input string nm);
    checkOutput({nm, "_pay_len"}, payLog.size(), expPay.size());
    for (int i = 0; i < expPay.size(); i++)
      checkOutput({nm, "_pay"}, (i < payLog.size()) ? 32'(payLog[i]) : 32'hDEAD, 32'(expPay[i]));
    checkOutput({nm, "_grant_len"}, grantLog.size(), expGrant.size());
    for (int i = 0; i < expGrant.size(); i++)
      checkOutput({nm, "_grant"}, (i < grantLog.size()) ? grantLog[i] : -1, expGrant[i]);
    checkOutput({nm, "_hdr_count"}, hdrLog.size(), HDR * expGrant.size());
  endtask

  initial begin
    for (int p = 0; p < N; p++) waitCnt[p] = -1;
    mOwner = -1; mPtr = N - 1; mGrant = 0; mHdr = 1'b0; mKnown = 1'b0;
    randValid = 1'b0; readyMode = 0; firstValid = -1;

    // Reset state
    applyReset();
    checkOutput("rst_grant_valid", grantValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_tready", sReady, 0);
    checkOutput("rst_m_tvalid", mValid, 0);
    checkOutput("rst_m_tdata", mData, 0);
    checkOutput("rst_grant_idx", grantIdx, 0);

    // Single-port packet from port 2
    clearLogs();
    addPacket(2, 3, 8'h41, -1, 0);
    waitDrain(100);
    expPay = '{8'h41, 8'h42, 8'h43};
    expGrant = '{2};
    checkLogs("t1");
    checkOutput("t1_latency", (payCyc.size() > 0) ? payCyc[0] - firstValid : -1, 1 + HDR);
    checkOutput("t1_consecutive", (payCyc.size() == 3) ? payCyc[2] - payCyc[0] : -1, 2);
    checkOutput("t1_gv_after", grantValid, 0);
`ifdef UART_TX_ARB_HEADER_EN
    checkOutput("t1_hdr_byte", (hdrLog.size() > 0) ? 32'(hdrLog[0]) : 32'hDEAD, 32'hF2);
`endif

    // Round-robin fairness, all ports loaded with single-beat packets
    applyReset();
    clearLogs();
    for (int p = 0; p < N; p++) addPacket(p, 1, 8'(16 * p), -1, 0);
    for (int p = 0; p < N; p++) addPacket(p, 1, 8'(16 * p + 1), -1, 0);
    waitDrain(200);
    expPay = '{8'h00, 8'h10, 8'h20, 8'h30, 8'h01, 8'h11, 8'h21, 8'h31};
    expGrant = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkLogs("t2");
    for (int i = 1; i < payCyc.size(); i++)
      checkOutput("t2_spacing", payCyc[i] - payCyc[i-1], 2 + HDR);

    // Wrap-around: after port 3, ports 1 and 3 together -> 1 then 3
    applyReset();
    addPacket(3, 1, 8'h33, -1, 0);
    waitDrain(100);
    clearLogs();
    addPacket(1, 2, 8'h61, -1, 0);
    addPacket(3, 2, 8'h71, -1, 0);
    waitDrain(100);
    expPay = '{8'h61, 8'h62, 8'h71, 8'h72};
    expGrant = '{1, 3};
    checkLogs("t3");

    // Backpressure 1,0,0,1 during a 4-beat packet from port 0
    applyReset();
    clearLogs();
    readyMode = 2;
    readyPat = '{1, 1, 0, 0, 1};
    addPacket(0, 4, 8'hA0, -1, 0);
    waitDrain(100);
    expPay = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    expGrant = '{0};
    checkLogs("t4");
    checkOutput("t4_stall", (payCyc.size() > 1) ? payCyc[1] - payCyc[0] : -1, (HDR != 0) ? 1 : 3);

    // Source gap of 3 cycles before the third beat; grant must be held
    readyMode = 0;
    clearLogs();
    addPacket(0, 4, 8'hB0, 2, 3);
    waitDrain(100);
    expPay = '{8'hB0, 8'hB1, 8'hB2, 8'hB3};
    expGrant = '{0};
    checkLogs("t4g");
    checkOutput("t4g_gap", (payCyc.size() > 2) ? payCyc[2] - payCyc[1] : -1, 4);

    // Reset after the 2nd of 5 beats
    applyReset();
    clearLogs();
    addPacket(0, 5, 8'hC0, -1, 0);
    for (int n = 0; n < 50 && payLog.size() < 2; n++) stepCycle();
    checkOutput("t5_reached", payLog.size() >= 2, 1);
    applyReset();
    checkOutput("t5_gv", grantValid, 0);
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_tready", sReady, 0);
    clearLogs();
    addPacket(1, 2, 8'hD0, -1, 0);
    waitDrain(100);
    expPay = '{8'hD0, 8'hD1};
    expGrant = '{1};
    checkLogs("t5");

`ifdef UART_TX_ARB_HEADER_EN
    // Header for a single-beat packet on port 3
    applyReset();
    clearLogs();
    addPacket(3, 1, 8'h55, -1, 0);
    waitDrain(100);
    checkOutput("t6_hdr", (hdrLog.size() > 0) ? 32'(hdrLog[0]) : 32'hDEAD, 32'hF3);
    checkOutput("t6_pay", (payLog.size() > 0) ? 32'(payLog[0]) : 32'hDEAD, 32'h55);
`endif

    // Randomized traffic with random valid/ready and one mid-traffic reset
    randValid = 1'b1;
    readyMode = 1;
    for (int r = 0; r < 3; r++) begin
      int left;
      applyReset();
      for (int k = 0; k < 20; k++) begin
        int len = 1 + int'($urandom % 5);
        int gapAt = ($urandom % 4 == 0) ? int'($urandom % len) : -1;
        addPacket(int'($urandom % N), len, 8'($urandom), gapAt, 1 + int'($urandom % 3));
      end
      if (r == 1) begin
        for (int n = 0; n < 40; n++) stepCycle();
        applyReset();
        for (int k = 0; k < 10; k++)
          addPacket(int'($urandom % N), 1 + int'($urandom % 4), 8'($urandom), -1, 0);
      end
      waitDrain(4000);
      left = 0;
      for (int p = 0; p < N; p++) left += refQ[p].size();
      checkOutput("rand_sb_empty", left, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
